// File: rtl/uart_tx_fifo_ip.sv
// Memory-mapped UART transmitter: TX FIFO, programmable baud divisor, 1/2 stop bits
// and a registered TX-done interrupt on the i_sel/i_we peripheral bus.
module uart_tx_fifo_ip #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 16,
  parameter int DATA_BITS   = 8,
  parameter int DIV_WIDTH   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_uart_tx,
  output logic        o_irq
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int DIV_RST = CLK_FREQ_HZ / BAUD_RATE - 1;
  localparam int LB      = DATA_BITS - 1;
  localparam logic [CW-1:0]        DEPTH_C   = FIFO_DEPTH[CW-1:0];
  localparam logic [DIV_WIDTH-1:0] DIV_RST_C = DIV_RST[DIV_WIDTH-1:0];
  localparam logic [2:0]           LAST_BIT  = LB[2:0];

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic [DIV_WIDTH-1:0] r_div;
  logic [1:0]           r_ctrl;
  logic                 r_ovf, r_irq, r_tx;
  logic [31:0]          r_rdata;

  state_t               r_state, w_state_next;
  logic [DIV_WIDTH-1:0] r_baud, w_baud_next;
  logic [2:0]           r_bit, w_bit_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_stop2, w_stop2_next, w_tx_next;

  logic        w_wr, w_rd, w_push, w_push_ok, w_pop;
  logic        w_empty, w_full, w_busy, w_bit_end, w_unused;
  logic [31:0] w_status, w_rd_mux;

  assign w_wr      = i_sel & i_we;
  assign w_rd      = i_sel & ~i_we;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_busy    = (r_state != S_IDLE);
  assign w_bit_end = (r_baud == '0);
  assign w_push    = w_wr && (i_addr == ADDR_DATA);
  // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_unused  = ^i_wdata;

  // NOTE: every signal gets a default before the case, otherwise paths that skip an
  // assignment infer latches.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_next    = r_tx;
    w_baud_next  = w_bit_end ? r_baud : r_baud - DIV_WIDTH'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_stop2_next = r_stop2;
    case (r_state)
      S_IDLE: begin
        w_baud_next = r_baud;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rptr];
          w_state_next = S_START;
          w_tx_next    = 1'b0;
          w_baud_next  = r_div;
        end
      end
      S_START: if (w_bit_end) begin
        w_state_next = S_DATA;
        w_bit_next   = '0;
        w_tx_next    = r_shift[0];
        w_baud_next  = r_div;
      end
      S_DATA: if (w_bit_end) begin
        w_baud_next = r_div;
        if (r_bit == LAST_BIT) begin
          w_state_next = S_STOP;
          w_stop2_next = 1'b0;
          w_tx_next    = 1'b1;
        end else begin
          w_bit_next   = r_bit + 3'd1;
          w_shift_next = r_shift >> 1;
          w_tx_next    = r_shift[1];
        end
      end
      S_STOP: if (w_bit_end) begin
        w_baud_next = r_div;
        if (r_ctrl[1] && !r_stop2) begin
          w_stop2_next = 1'b1;
        end else if (!w_empty) begin
          // Back-to-back frame: skip IDLE so there is no gap on the line.
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rptr];
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_stop2 <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_stop2 <= w_stop2_next;
    end
  end

  always_comb begin
    w_status        = '0;
    w_status[0]     = w_busy;
    w_status[1]     = w_empty;
    w_status[2]     = r_ovf;
    w_status[9]     = w_full;
    w_status[23:16] = 8'(r_count);
    case (i_addr)
      ADDR_STATUS: w_rd_mux = w_status;
      ADDR_DIV:    w_rd_mux = 32'(r_div);
      ADDR_CTRL:   w_rd_mux = {30'b0, r_ctrl};
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_div   <= DIV_RST_C;
      r_ctrl  <= '0;
      r_ovf   <= 1'b0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr && i_addr == ADDR_DIV)  r_div  <= i_wdata[DIV_WIDTH-1:0];
      if (w_wr && i_addr == ADDR_CTRL) r_ctrl <= i_wdata[1:0];
      // Set beats clear when an overflowing push meets a clear write.
      if (w_push && !w_push_ok)
        r_ovf <= 1'b1;
      else if (w_wr && i_addr == ADDR_STATUS && i_wdata[2])
        r_ovf <= 1'b0;
      if (w_rd) r_rdata <= w_rd_mux;
      r_irq <= r_ctrl[0] & w_empty & ~w_busy;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers and count define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata[DATA_BITS-1:0];
  end

  assign o_rdata   = r_rdata;
  assign o_uart_tx = r_tx;
  assign o_irq     = r_irq;

endmodule
